// File: rtl/matmul_gen_pkg.sv
// Shared definitions for matmul_gen: controller state type and read-latency limits.
package matmul_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    WRITE,
    FINISH
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Keeps pipeline depths legal even if an out-of-range latency is configured.
  function automatic int clampLat(input int lat);
    if (lat < RD_LAT_MIN) return RD_LAT_MIN;
    if (lat > RD_LAT_MAX) return RD_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/matmul_gen_mac.sv
// Signed multiply-accumulate for one Z element, tracking read latency with a valid/first pipe.
// Optional saturating result reduction is enabled by defining MATMUL_GEN_SAT_EN.
module matmul_gen_mac
  import matmul_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 72,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  issue_i,
  input  logic                  first_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  localparam int LAT = clampLat(RD_LAT);
  localparam int PW  = 2 * DATA_WIDTH;

  logic [LAT-1:0]              vld_q;
  logic [LAT-1:0]              first_q;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prodExt;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign prod    = $signed(a_i) * $signed(b_i);
  assign prodExt = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};

  // The first product of an element replaces whatever the previous element left behind.
  always_comb begin
    acc_d = acc_q;
    if (vld_q[LAT-1]) begin
      acc_d = first_q[LAT-1] ? prodExt : acc_q + prodExt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vld_q   <= '0;
      first_q <= '0;
      acc_q   <= '0;
    end else begin
      vld_q[0]   <= issue_i;
      first_q[0] <= first_i;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s]   <= vld_q[s-1];
        first_q[s] <= first_q[s-1];
      end
      acc_q <= acc_d;
    end
  end

`ifdef MATMUL_GEN_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    res_o = acc_d[DATA_WIDTH-1:0];
    if (acc_d > SAT_MAX) begin
      res_o = SAT_MAX[DATA_WIDTH-1:0];
    end else if (acc_d < SAT_MIN) begin
      res_o = SAT_MIN[DATA_WIDTH-1:0];
    end
  end
`else
  assign res_o = acc_d[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/matmul_gen.sv
// Sequential matrix multiplier Z = X*Y: one element at a time, one operand read per cycle.
// Define MATMUL_GEN_SAT_EN to saturate results instead of wrapping them.
module matmul_gen
  import matmul_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 72,
  parameter int M          = 8,
  parameter int K          = 8,
  parameter int N          = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LAT     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] x_addr,
  output logic [ADDR_WIDTH-1:0] y_addr,
  input  logic [DATA_WIDTH-1:0] x_dout,
  input  logic [DATA_WIDTH-1:0] y_dout,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] z_din,
  output logic                  z_wr_en
);

  localparam int LAT = clampLat(RD_LAT);
  localparam logic [ADDR_WIDTH-1:0] M_LAST   = ADDR_WIDTH'(M - 1);
  localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(K - 1);
  localparam logic [ADDR_WIDTH-1:0] N_LAST   = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] LAT_LAST = ADDR_WIDTH'(LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] K_STEP   = ADDR_WIDTH'(K);
  localparam logic [ADDR_WIDTH-1:0] N_STEP   = ADDR_WIDTH'(N);

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   i_q, j_q, k_q;
  logic [ADDR_WIDTH-1:0]   xBase_q, zIdx_q;
  logic [ADDR_WIDTH-1:0]   xAddr_q, yAddr_q, zAddr_q;
  logic [DATA_WIDTH-1:0]   zDin_q;
  logic                    busy_q, done_q, zWrEn_q;
  logic [DATA_WIDTH-1:0]   macRes;
  logic                    lastCol, lastElem;

  assign lastCol  = (j_q == N_LAST);
  assign lastElem = lastCol && (i_q == M_LAST);

  matmul_gen_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH),
    .RD_LAT    (LAT)
  ) uMac (
    .clk_i  (clock),
    .reset_i(reset),
    .issue_i(state_q == RUN),
    .first_i((state_q == RUN) && (k_q == '0)),
    .a_i    (x_dout),
    .b_i    (y_dout),
    .res_o  (macRes)
  );

  // Addresses are walked incrementally: x steps by 1 and y by N within an element,
  // while xBase tracks i*K and zIdx tracks the row-major output index i*N+j.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      xBase_q <= '0;
      zIdx_q  <= '0;
      xAddr_q <= '0;
      yAddr_q <= '0;
      zAddr_q <= '0;
      zDin_q  <= '0;
      zWrEn_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      zWrEn_q <= 1'b0;
      done_q  <= 1'b0;
      zAddr_q <= '0;
      zDin_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            xBase_q <= '0;
            zIdx_q  <= '0;
            xAddr_q <= '0;
            yAddr_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (k_q == K_LAST) begin
            state_q <= DRAIN;
            k_q     <= '0;
            xAddr_q <= '0;
            yAddr_q <= '0;
          end else begin
            k_q     <= k_q + 1'b1;
            xAddr_q <= xAddr_q + 1'b1;
            yAddr_q <= yAddr_q + N_STEP;
          end
        end
        DRAIN: begin
          // macRes already includes the product landing on this edge.
          if (k_q == LAT_LAST) begin
            state_q <= WRITE;
            zWrEn_q <= 1'b1;
            zAddr_q <= zIdx_q;
            zDin_q  <= macRes;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        WRITE: begin
          zIdx_q <= zIdx_q + 1'b1;
          k_q    <= '0;
          if (lastElem) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
            if (lastCol) begin
              j_q     <= '0;
              i_q     <= i_q + 1'b1;
              xBase_q <= xBase_q + K_STEP;
              xAddr_q <= xBase_q + K_STEP;
              yAddr_q <= '0;
            end else begin
              j_q     <= j_q + 1'b1;
              xAddr_q <= xBase_q;
              yAddr_q <= j_q + 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign x_addr  = xAddr_q;
  assign y_addr  = yAddr_q;
  assign z_addr  = zAddr_q;
  assign z_din   = zDin_q;
  assign z_wr_en = zWrEn_q;

endmodule

// File: tb/tb_matmul_gen.sv
// Directed bench for matmul_gen: three configurations sharing one clock and reset,
// each with its own operand memories and a log of every result write.
module tb_matmul_gen;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    string       name;
    int          unit;
    int          idx;
    logic [31:0] exp;
  } zVec_t;

  typedef struct {
    string      name;
    logic [7:0] xv;
    logic [7:0] yv;
    logic [7:0] exp;
  } satVec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Unit A: 2x2x2, 32-bit, read latency 1
  logic        startA, busyA, doneA, zWrEnA;
  logic [5:0]  xAddrA, yAddrA, zAddrA;
  logic [31:0] xDoutA, yDoutA, zDinA;
  logic [31:0] xMemA [0:63];
  logic [31:0] yMemA [0:63];
  wr_t         logA[$];
  int          doneCntA = 0;

  // Unit B: 2x3x4, 32-bit, read latency 2
  logic        startB, busyB, doneB, zWrEnB;
  logic [5:0]  xAddrB, yAddrB, zAddrB;
  logic [31:0] xDoutB, yDoutB, zDinB, xPipeB, yPipeB;
  logic [31:0] xMemB [0:63];
  logic [31:0] yMemB [0:63];
  wr_t         logB[$];

  // Unit C: 1x4x2, 8-bit, read latency 1
  logic        startC, busyC, doneC, zWrEnC;
  logic [5:0]  xAddrC, yAddrC, zAddrC;
  logic [7:0]  xDoutC, yDoutC, zDinC;
  logic [7:0]  xMemC [0:63];
  logic [7:0]  yMemC [0:63];
  wr_t         logC[$];

  matmul_gen #(.DATA_WIDTH(32), .ACC_WIDTH(72), .M(2), .K(2), .N(2), .ADDR_WIDTH(6), .RD_LAT(1)) dutA (
    .clock(clock), .reset(reset), .start(startA), .busy(busyA), .done(doneA),
    .x_addr(xAddrA), .y_addr(yAddrA), .x_dout(xDoutA), .y_dout(yDoutA),
    .z_addr(zAddrA), .z_din(zDinA), .z_wr_en(zWrEnA));

  matmul_gen #(.DATA_WIDTH(32), .ACC_WIDTH(72), .M(2), .K(3), .N(4), .ADDR_WIDTH(6), .RD_LAT(2)) dutB (
    .clock(clock), .reset(reset), .start(startB), .busy(busyB), .done(doneB),
    .x_addr(xAddrB), .y_addr(yAddrB), .x_dout(xDoutB), .y_dout(yDoutB),
    .z_addr(zAddrB), .z_din(zDinB), .z_wr_en(zWrEnB));

  matmul_gen #(.DATA_WIDTH(8), .ACC_WIDTH(24), .M(1), .K(4), .N(2), .ADDR_WIDTH(6), .RD_LAT(1)) dutC (
    .clock(clock), .reset(reset), .start(startC), .busy(busyC), .done(doneC),
    .x_addr(xAddrC), .y_addr(yAddrC), .x_dout(xDoutC), .y_dout(yDoutC),
    .z_addr(zAddrC), .z_din(zDinC), .z_wr_en(zWrEnC));

  // Synchronous operand memories with the configured read latency.
  always @(posedge clock) begin
    xDoutA <= xMemA[xAddrA];
    yDoutA <= yMemA[yAddrA];
    xPipeB <= xMemB[xAddrB];
    yPipeB <= yMemB[yAddrB];
    xDoutB <= xPipeB;
    yDoutB <= yPipeB;
    xDoutC <= xMemC[xAddrC];
    yDoutC <= yMemC[yAddrC];
  end

  // Result-port monitors log each write and count done pulses mid-cycle.
  always @(negedge clock) begin
    if (zWrEnA) logA.push_back('{zAddrA, zDinA});
    if (zWrEnB) logB.push_back('{zAddrB, zDinB});
    if (zWrEnC) logC.push_back('{zAddrC, {24'd0, zDinC}});
    if (doneA) doneCntA <= doneCntA + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setStart(input int unit, input logic v);
    case (unit)
      0: startA = v;
      1: startB = v;
      default: startC = v;
    endcase
  endtask

  function automatic logic getDone(input int unit);
    case (unit)
      0: return doneA;
      1: return doneB;
      default: return doneC;
    endcase
  endfunction

  function automatic logic getBusy(input int unit);
    case (unit)
      0: return busyA;
      1: return busyB;
      default: return busyC;
    endcase
  endfunction

  function automatic logic [31:0] fetchData(input int unit, input int pos);
    case (unit)
      0: if (pos < logA.size()) return logA[pos].data;
      1: if (pos < logB.size()) return logB[pos].data;
      default: if (pos < logC.size()) return logC[pos].data;
    endcase
    return 'x;
  endfunction

  // Starts a unit and measures the cycle in which done appears; the cycle holding
  // the start request is cycle 0, so the cycle after the sampling edge is cycle 1.
  task automatic applyStimulus(input int unit, input int expCycles, input string name);
    int   cyc;
    logic seen;
    setStart(unit, 1'b1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 2000) begin
      stepCycles(1);
      cyc++;
      if (cyc == 1) setStart(unit, 1'b0);
      seen = getDone(unit);
    end
    checkOutput({name, " done cycle"}, 64'(cyc), 64'(expCycles));
    stepCycles(1);
    checkOutput({name, " done width"}, 64'(getDone(unit)), 64'd0);
    checkOutput({name, " idle after"}, 64'(getBusy(unit)), 64'd0);
  endtask

  zVec_t   zTab   [12];
  satVec_t satTab [2];
  int      baseA, baseB, baseC, baseDone;

  initial begin
    zTab = '{
      '{"A z00", 0, 0, 32'd1},       '{"A z01", 0, 1, 32'd2},
      '{"A z10", 0, 2, 32'd3},       '{"A z11", 0, 3, 32'd4},
      '{"B z00", 1, 0, -32'sd3},     '{"B z01", 1, 1, 32'd0},
      '{"B z02", 1, 2, 32'd3},       '{"B z03", 1, 3, 32'd6},
      '{"B z10", 1, 4, -32'sd3},     '{"B z11", 1, 5, 32'd0},
      '{"B z12", 1, 6, 32'd3},       '{"B z13", 1, 7, 32'd6}
    };
`ifdef MATMUL_GEN_SAT_EN
    satTab = '{'{"C pos", 8'd127, 8'd127, 8'h7F}, '{"C neg", 8'h80, 8'd127, 8'h80}};
`else
    satTab = '{'{"C pos", 8'd127, 8'd127, 8'h04}, '{"C neg", 8'h80, 8'd127, 8'h00}};
`endif

    for (int a = 0; a < 64; a++) begin
      xMemA[a] = '0; yMemA[a] = '0; xMemB[a] = '0; yMemB[a] = '0;
      xMemC[a] = '0; yMemC[a] = '0;
    end
    xMemA[0] = 32'd1; xMemA[1] = 32'd2; xMemA[2] = 32'd3; xMemA[3] = 32'd4;
    yMemA[0] = 32'd1; yMemA[3] = 32'd1;
    for (int a = 0; a < 6; a++) xMemB[a] = 32'd1;
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 4; j++) yMemB[k*4+j] = 32'(j - k);

    reset  = 1'b1;
    startA = 1'b0;
    startB = 1'b0;
    startC = 1'b0;
    stepCycles(3);
    checkOutput("reset busy", 64'(busyA), 64'd0);
    checkOutput("reset done", 64'(doneA), 64'd0);
    checkOutput("reset wr_en", 64'(zWrEnA), 64'd0);
    checkOutput("reset z_din", 64'(zDinA), 64'd0);
    checkOutput("reset x_addr", 64'(xAddrA), 64'd0);
    checkOutput("reset busyB", 64'(busyB), 64'd0);
    reset = 1'b0;
    stepCycles(2);

    baseA = logA.size();
    applyStimulus(0, 17, "A");
    checkOutput("A write count", 64'(logA.size() - baseA), 64'd4);
    for (int p = 0; p < 4; p++)
      if (baseA + p < logA.size())
        checkOutput($sformatf("A write addr %0d", p), 64'(logA[baseA+p].addr), 64'(p));

    baseB = logB.size();
    applyStimulus(1, 49, "B");
    checkOutput("B write count", 64'(logB.size() - baseB), 64'd8);

    for (int v = 0; v < 12; v++)
      checkOutput(zTab[v].name,
                  64'(fetchData(zTab[v].unit, (zTab[v].unit == 0 ? baseA : baseB) + zTab[v].idx)),
                  64'(zTab[v].exp));

    for (int v = 0; v < 2; v++) begin
      for (int a = 0; a < 4; a++) xMemC[a] = satTab[v].xv;
      for (int a = 0; a < 8; a++) yMemC[a] = satTab[v].yv;
      baseC = logC.size();
      applyStimulus(2, 13, satTab[v].name);
      checkOutput({satTab[v].name, " z0"}, 64'(fetchData(2, baseC)), 64'(satTab[v].exp));
      checkOutput({satTab[v].name, " z1"}, 64'(fetchData(2, baseC + 1)), 64'(satTab[v].exp));
    end

    // Reset during the third element's RUN, then a clean rerun.
    baseA = logA.size();
    setStart(0, 1'b1);
    stepCycles(1);
    setStart(0, 1'b0);
    checkOutput("run x_addr k0", 64'(xAddrA), 64'd0);
    checkOutput("run y_addr k0", 64'(yAddrA), 64'd0);
    stepCycles(1);
    checkOutput("run x_addr k1", 64'(xAddrA), 64'd1);
    checkOutput("run y_addr k1", 64'(yAddrA), 64'd2);
    stepCycles(7);
    reset = 1'b1;
    stepCycles(1);
    checkOutput("mid reset busy", 64'(busyA), 64'd0);
    checkOutput("mid reset done", 64'(doneA), 64'd0);
    checkOutput("mid reset wr_en", 64'(zWrEnA), 64'd0);
    reset = 1'b0;
    stepCycles(12);
    checkOutput("mid reset writes", 64'(logA.size() - baseA), 64'd2);
    checkOutput("mid reset stays idle", 64'(busyA), 64'd0);
    baseA = logA.size();
    applyStimulus(0, 17, "A rerun");
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("A rerun z%0d", p), 64'(fetchData(0, baseA + p)), 64'(p + 1));

    // Start re-pulsed mid-run and held through FINISH.
    baseA    = logA.size();
    baseDone = doneCntA;
    setStart(0, 1'b1);
    stepCycles(1);
    setStart(0, 1'b0);
    stepCycles(4);
    setStart(0, 1'b1);
    stepCycles(1);
    setStart(0, 1'b0);
    checkOutput("repulse busy", 64'(busyA), 64'd1);
    stepCycles(9);
    setStart(0, 1'b1);
    stepCycles(1);
    checkOutput("held done c16", 64'(doneA), 64'd0);
    stepCycles(1);
    checkOutput("held done c17", 64'(doneA), 64'd1);
    stepCycles(1);
    setStart(0, 1'b0);
    checkOutput("held idle c18", 64'(busyA), 64'd0);
    stepCycles(3);
    checkOutput("held no restart", 64'(busyA), 64'd0);
    checkOutput("held done pulses", 64'(doneCntA - baseDone), 64'd1);
    checkOutput("held writes", 64'(logA.size() - baseA), 64'd4);
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("held z%0d", p), 64'(fetchData(0, baseA + p)), 64'(p + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
